// File: rtl/rp_cmp_sched_if.sv
// Request/response channel between the comparison sequencer and the shared
// pruned-distance datapath. The master issues one (class, segment) request
// and receives one partial Hamming distance back.
interface rp_cmp_sched_if #(
    parameter int CLS_W = 5,
    parameter int SEG_W = 2,
    parameter int PD_W  = 11
);
    logic             dp_req_valid;
    logic             dp_req_ready;
    logic [CLS_W-1:0] dp_class_idx;
    logic [SEG_W-1:0] dp_seg_idx;
    logic             dp_rsp_valid;
    logic [PD_W-1:0]  dp_rsp_dist;

    modport master (
        output dp_req_valid,
        input  dp_req_ready,
        output dp_class_idx,
        output dp_seg_idx,
        input  dp_rsp_valid,
        input  dp_rsp_dist
    );

    modport slave (
        input  dp_req_valid,
        output dp_req_ready,
        input  dp_class_idx,
        input  dp_seg_idx,
        output dp_rsp_valid,
        output dp_rsp_dist
    );
endinterface

// File: rtl/rp_cmp_sched.sv
// Segmented query-vs-class Hamming comparison sequencer.
// Walks every class HV and every dimension segment, issues one request at a
// time to the shared pruned-distance datapath, accumulates the partial
// distances per class and tracks the running arg-min (ties keep the lower
// class index). Reports the predicted class with a one-cycle done pulse.
// Optional build macro RP_CMP_EARLY_EXIT_EN: abandon a class as soon as its
// partial sum can no longer beat the current best.
module rp_cmp_sched #(
    parameter int NUM_CLASSES  = 26,
    parameter int SEQ_CYCLES   = 4,
    parameter int DIMS_PER_SEG = 1024,
    parameter int CLS_W        = $clog2(NUM_CLASSES),
    parameter int SEG_W        = $clog2(SEQ_CYCLES),
    parameter int PD_W         = $clog2(DIMS_PER_SEG + 1),
    parameter int AD_W         = $clog2(SEQ_CYCLES * DIMS_PER_SEG + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    rp_cmp_sched_if.master   dp,
    output logic             busy,
    output logic             done,
    output logic [CLS_W-1:0] pred_class,
    output logic [AD_W-1:0]  pred_dist
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CLS_W-1:0] cls_q;
    logic [SEG_W-1:0] seg_q;
    logic [AD_W-1:0]  acc_q;
    logic [AD_W-1:0]  best_dist_q;
    logic [CLS_W-1:0] best_cls_q;
    logic [AD_W-1:0]  acc_sum;
    logic             seg_last;
    logic             cls_last;
    logic             early_exit;

    // Partial sum can never exceed SEQ_CYCLES*DIMS_PER_SEG, so AD_W holds it.
    assign acc_sum  = acc_q + AD_W'(dp.dp_rsp_dist);
    assign seg_last = (seg_q == SEG_W'(SEQ_CYCLES - 1));
    assign cls_last = (cls_q == CLS_W'(NUM_CLASSES - 1));

`ifdef RP_CMP_EARLY_EXIT_EN
    // Class 0 always runs to completion so best_dist is a real distance.
    assign early_exit = (cls_q != '0) && (acc_sum >= best_dist_q);
`else
    assign early_exit = 1'b0;
`endif

    assign dp.dp_class_idx = cls_q;
    assign dp.dp_seg_idx   = seg_q;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-driven outputs.
    always_comb begin
        state_d         = state_q;
        dp.dp_req_valid = 1'b0;
        busy            = (state_q != IDLE);
        done            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                dp.dp_req_valid = 1'b1;
                if (dp.dp_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (dp.dp_rsp_valid) begin
                    if (seg_last || early_exit) state_d = EVAL;
                    else                        state_d = ISSUE;
                end
            end
            EVAL: begin
                state_d = cls_last ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Class/segment walk, accumulation, arg-min tracking and result capture.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cls_q       <= '0;
            seg_q       <= '0;
            acc_q       <= '0;
            best_dist_q <= '1;
            best_cls_q  <= '0;
            pred_class  <= '0;
            pred_dist   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cls_q       <= '0;
                        seg_q       <= '0;
                        acc_q       <= '0;
                        best_dist_q <= '1;
                        best_cls_q  <= '0;
                    end
                end
                WAIT: begin
                    if (dp.dp_rsp_valid) begin
                        acc_q <= acc_sum;
                        if (state_d == ISSUE) seg_q <= seg_q + SEG_W'(1);
                    end
                end
                EVAL: begin
                    if (acc_q < best_dist_q) begin
                        best_dist_q <= acc_q;
                        best_cls_q  <= cls_q;
                    end
                    acc_q <= '0;
                    seg_q <= '0;
                    if (!cls_last) cls_q <= cls_q + CLS_W'(1);
                end
                DONE: begin
                    pred_class <= best_cls_q;
                    pred_dist  <= best_dist_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rp_cmp_sched.sv
// Directed testbench for rp_cmp_sched. A behavioural datapath answers each
// accepted request one cycle later with a distance from a per-scenario table.
module tb_rp_cmp_sched;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  pred_class;
    logic [12:0] pred_dist;

    int errors = 0;
    int checks = 0;

    rp_cmp_sched_if #(.CLS_W(5), .SEG_W(2), .PD_W(11)) dp_if ();

    rp_cmp_sched dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .dp         (dp_if),
        .busy       (busy),
        .done       (done),
        .pred_class (pred_class),
        .pred_dist  (pred_dist)
    );

    always #5 clk = ~clk;

    // Per-scenario partial distance for (class, segment).
    function automatic int dist_of(input int mode, input int c, input int s);
        case (mode)
            0:       return (c == 9) ? 100 : 200;
            1:       return (c == 3 || c == 17) ? ((s == 0) ? 50 : 0) : 250;
            default: return (c == 0) ? 10 : ((s == 0) ? 1024 : 0);
        endcase
    endfunction

    // Runs one comparison from IDLE. Inputs change on the falling edge; the
    // loop index cyc is the cycle number counted from the start-sampling edge.
    task automatic run_dp(input int mode, input bit stall_en, input bit spur_en,
                          input bit abort_en, output int done_cyc,
                          output int nreq, output int ndone);
        int cyc;
        bit pend;
        int pc;
        int ps;
        int stall_left;
        bit spur_done;
        done_cyc   = 0;
        nreq       = 0;
        ndone      = 0;
        pend       = 0;
        pc         = 0;
        ps         = 0;
        stall_left = 5;
        spur_done  = 0;
        start = 1'b1;
        dp_if.dp_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 1500) begin
            if (abort_en && pend && pc == 7 && ps == 2) begin
                dp_if.dp_rsp_valid = 1'b0;
                dp_if.dp_rsp_dist  = '0;
                return;
            end
            dp_if.dp_rsp_valid = 1'b0;
            dp_if.dp_rsp_dist  = '0;
            start = (spur_en && cyc == 50);
            if (pend) begin
                dp_if.dp_rsp_valid = 1'b1;
                dp_if.dp_rsp_dist  = 11'(dist_of(mode, pc, ps));
                pend = 0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (ndone > 0 && cyc >= done_cyc + 10) break;
            if (stall_en && stall_left > 0 &&
                (stall_left < 5 || (dp_if.dp_req_valid === 1'b1 &&
                 dp_if.dp_class_idx == 5'd0 && dp_if.dp_seg_idx == 2'd1))) begin
                if (stall_left < 5) begin
                    checks++;
                    if (dp_if.dp_req_valid !== 1'b1 || dp_if.dp_class_idx !== 5'd0 ||
                        dp_if.dp_seg_idx !== 2'd1) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b class=%0d seg=%0d required 1/0/1",
                                 dp_if.dp_req_valid, dp_if.dp_class_idx, dp_if.dp_seg_idx);
                    end
                end
                dp_if.dp_req_ready = 1'b0;
                stall_left--;
            end else begin
                dp_if.dp_req_ready = 1'b1;
                if (dp_if.dp_req_valid === 1'b1) begin
                    pend = 1;
                    pc   = int'(dp_if.dp_class_idx);
                    ps   = int'(dp_if.dp_seg_idx);
                    nreq++;
                end else if (spur_en && !spur_done && cyc >= 20) begin
                    spur_done = 0;
                end
            end
            // Spurious response while a request is still being offered.
            if (spur_en && !spur_done && cyc >= 20 && dp_if.dp_req_valid === 1'b1 && !pend) begin
                spur_done = 1;
            end
            if (spur_en && !spur_done && cyc >= 20 && dp_if.dp_req_valid === 1'b1) begin
                dp_if.dp_rsp_valid = 1'b1;
                dp_if.dp_rsp_dist  = '0;
                spur_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        dp_if.dp_rsp_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (dp_if.dp_req_valid !== 1'b0 || dp_if.dp_class_idx !== 5'd0 ||
            dp_if.dp_seg_idx !== 2'd0) begin
            errors++;
            $display("FAIL %s_req: valid=%b class=%0d seg=%0d required 0/0/0", tag,
                     dp_if.dp_req_valid, dp_if.dp_class_idx, dp_if.dp_seg_idx);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: busy=%b done=%b required 0/0", tag, busy, done);
        end
        checks++;
        if (pred_class !== 5'd0 || pred_dist !== 13'd0) begin
            errors++;
            $display("FAIL %s_pred: class=%0d dist=%0d required 0/0", tag, pred_class, pred_dist);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        dp_if.dp_req_ready = 1'b0;
        dp_if.dp_rsp_valid = 1'b0;
        dp_if.dp_rsp_dist  = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("post_reset_idle");
    endtask

    task automatic test_full_sweep();
        int dc, nr, nd;
        int exp_cyc, exp_req;
`ifdef RP_CMP_EARLY_EXIT_EN
        exp_cyc = 171; exp_req = 72;
`else
        exp_cyc = 235; exp_req = 104;
`endif
        run_dp(0, 0, 0, 0, dc, nr, nd);
        checks++;
        if (dc !== exp_cyc) begin errors++; $display("FAIL sweep_latency: done cycle %0d required %0d", dc, exp_cyc); end
        checks++;
        if (nr !== exp_req) begin errors++; $display("FAIL sweep_requests: %0d required %0d", nr, exp_req); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL sweep_done_count: %0d required 1", nd); end
        checks++;
        if (pred_class !== 5'd9) begin errors++; $display("FAIL sweep_class: %0d required 9", pred_class); end
        checks++;
        if (pred_dist !== 13'd400) begin errors++; $display("FAIL sweep_dist: %0d required 400", pred_dist); end
    endtask

    task automatic test_reset_mid_run();
        int dc, nr, nd;
        run_dp(0, 0, 0, 1, dc, nr, nd);
        checks++;
        if (busy !== 1'b1 || dp_if.dp_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_in_wait: busy=%b valid=%b required 1/0", busy, dp_if.dp_req_valid);
        end
        nrst = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || dp_if.dp_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrun_after_release: busy=%b valid=%b required 0/0", busy, dp_if.dp_req_valid);
            end
        end
    endtask

    task automatic test_tie();
        int dc, nr, nd;
        run_dp(1, 0, 0, 0, dc, nr, nd);
        checks++;
        if (pred_class !== 5'd3) begin errors++; $display("FAIL tie_class: %0d required 3", pred_class); end
        checks++;
        if (pred_dist !== 13'd50) begin errors++; $display("FAIL tie_dist: %0d required 50", pred_dist); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL tie_done_count: %0d required 1", nd); end
    endtask

    task automatic test_backpressure();
        int dc, nr, nd;
        int exp_cyc;
`ifdef RP_CMP_EARLY_EXIT_EN
        exp_cyc = 176;
`else
        exp_cyc = 240;
`endif
        run_dp(0, 1, 0, 0, dc, nr, nd);
        checks++;
        if (dc !== exp_cyc) begin errors++; $display("FAIL bp_latency: done cycle %0d required %0d", dc, exp_cyc); end
        checks++;
        if (pred_class !== 5'd9 || pred_dist !== 13'd400) begin
            errors++;
            $display("FAIL bp_result: class=%0d dist=%0d required 9/400", pred_class, pred_dist);
        end
    endtask

    task automatic test_spurious();
        int dc, nr, nd;
        int exp_cyc, exp_req;
`ifdef RP_CMP_EARLY_EXIT_EN
        exp_cyc = 171; exp_req = 72;
`else
        exp_cyc = 235; exp_req = 104;
`endif
        run_dp(0, 0, 1, 0, dc, nr, nd);
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL spur_done_count: %0d required 1", nd); end
        checks++;
        if (dc !== exp_cyc) begin errors++; $display("FAIL spur_latency: done cycle %0d required %0d", dc, exp_cyc); end
        checks++;
        if (nr !== exp_req) begin errors++; $display("FAIL spur_requests: %0d required %0d", nr, exp_req); end
        checks++;
        if (pred_class !== 5'd9 || pred_dist !== 13'd400) begin
            errors++;
            $display("FAIL spur_result: class=%0d dist=%0d required 9/400", pred_class, pred_dist);
        end
    endtask

    task automatic test_early_exit();
        int dc, nr, nd;
        int exp_req;
`ifdef RP_CMP_EARLY_EXIT_EN
        exp_req = 29;
`else
        exp_req = 104;
`endif
        run_dp(2, 0, 0, 0, dc, nr, nd);
        checks++;
        if (nr !== exp_req) begin errors++; $display("FAIL early_requests: %0d required %0d", nr, exp_req); end
        checks++;
        if (pred_class !== 5'd0 || pred_dist !== 13'd40) begin
            errors++;
            $display("FAIL early_result: class=%0d dist=%0d required 0/40", pred_class, pred_dist);
        end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL early_done_count: %0d required 1", nd); end
    endtask

    initial begin
        dp_if.dp_req_ready = 1'b0;
        dp_if.dp_rsp_valid = 1'b0;
        dp_if.dp_rsp_dist  = '0;
        @(negedge clk);
        test_reset();
        test_full_sweep();
        test_reset_mid_run();
        test_tie();
        test_backpressure();
        test_spurious();
        test_early_exit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
